// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared fun3 codes, FSM state type and sizing helper for the LSU memory initiator
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } lsu_state_e;

   // Bits needed to hold the word count itself, so a power-of-two depth still compares correctly.
   function automatic int unsigned mem_word_bits(input int unsigned words);
      return $clog2(words + 1);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - sub-word load extraction and store lane merge against a full memory word
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  fun3,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{off, 3'b000} +: 8];
      half_sel = off[1] ? word[31:16] : word[15:0];
      case (fun3)
         F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_data = {24'h0, byte_sel};
         F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_data = {16'h0, half_sel};
         default: load_data = word;
      endcase
   end

   always_comb begin
      merged_word = word;
      case (fun3)
         F3_B:    merged_word[{off, 3'b000} +: 8] = wdata[7:0];
         F3_H:    merged_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
         default: merged_word = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - load/store initiator to a word-only data memory with read-modify-write for SB/SH
module lsu_mem_initiator
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 40
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_fun3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_fun3,
   output logic        mem_rd_en,
   output logic        mem_wd_en,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned AW = mem_word_bits(MEM_WORDS);

   lsu_state_e  state;
   logic        cap_store;
   logic [2:0]  cap_fun3;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic        req_err;
   logic [31:0] load_data;
   logic [31:0] merged_word;

   assign req_ready   = (state == ST_IDLE);
   assign mem_address = {2'b00, cap_addr[31:2]};
   assign mem_fun3    = F3_W;

   always_comb begin
      req_err = 1'b0;
      case (req_fun3)
         F3_B, F3_BU: req_err = 1'b0;
         F3_H, F3_HU: req_err = req_addr[0];
         F3_W:        req_err = (req_addr[1:0] != 2'b00);
         default:     req_err = 1'b1;
      endcase
      if (req_store && (req_fun3 == F3_BU || req_fun3 == F3_HU))
         req_err = 1'b1;
      if (((req_addr[31:2] >> AW) != '0) || (req_addr[AW+1:2] >= AW'(MEM_WORDS)))
         req_err = 1'b1;
   end

   // The memory read is combinational, so extraction and merge work straight off mem_rdata in READ.
   lsu_lane_align u_lane_align (
      .word        (mem_rdata),
      .off         (cap_addr[1:0]),
      .fun3        (cap_fun3),
      .wdata       (cap_wdata),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cap_store  <= 1'b0;
         cap_fun3   <= 3'b000;
         cap_addr   <= 32'h0;
         cap_wdata  <= 32'h0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
         mem_wdata  <= 32'h0;
         mem_rd_en  <= 1'b0;
         mem_wd_en  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  cap_store <= req_store;
                  cap_fun3  <= req_fun3;
                  cap_addr  <= req_addr;
                  cap_wdata <= req_wdata;
                  if (req_err) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                  end else if (!req_store || req_fun3 != F3_W) begin
                     state     <= ST_READ;
                     mem_rd_en <= 1'b1;
                  end else begin
                     state     <= ST_WRITE;
                     mem_wd_en <= 1'b1;
                     mem_wdata <= req_wdata;
                  end
               end
            end
            ST_READ: begin
               mem_rd_en <= 1'b0;
               if (cap_store) begin
                  state     <= ST_WRITE;
                  mem_wd_en <= 1'b1;
                  mem_wdata <= merged_word;
               end else begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= load_data;
               end
            end
            ST_WRITE: begin
               mem_wd_en  <= 1'b0;
               state      <= ST_RESP;
               resp_valid <= 1'b1;
               resp_rdata <= 32'h0;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state      <= ST_IDLE;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - randomized self-checking bench for lsu_mem_initiator against a word-array model
module tb_lsu_mem_initiator;

   localparam int MEM_WORDS = 40;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_fun3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_fun3;
   logic        mem_rd_en;
   logic        mem_wd_en;
   logic [31:0] mem_rdata;

   logic [31:0] mem     [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];
   int          rd_cnt = 0;
   int          wd_cnt = 0;
   int          both_cnt = 0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   lsu_mem_initiator #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_store   (req_store),
      .req_fun3    (req_fun3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_fun3    (mem_fun3),
      .mem_rd_en   (mem_rd_en),
      .mem_wd_en   (mem_wd_en),
      .mem_rdata   (mem_rdata)
   );

   always_comb begin
      mem_rdata = 32'h0;
      if (mem_rd_en && mem_address < MEM_WORDS)
         mem_rdata = mem[mem_address];
   end

   always @(posedge clk) begin
      if (mem_wd_en && mem_address < MEM_WORDS)
         mem[mem_address] <= mem_wdata;
      if (mem_rd_en) rd_cnt <= rd_cnt + 1;
      if (mem_wd_en) wd_cnt <= wd_cnt + 1;
      if (mem_rd_en && mem_wd_en) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Architectural expectation of one request; updates the reference memory for good stores.
   task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic err, output logic [31:0] rd, output int lat);
      longint unsigned idx, off, size, mask, w, v;
      idx  = longint'(a) / 4;
      off  = longint'(a) % 4;
      size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      err  = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (st && (f3 == 3'd4 || f3 == 3'd5))
             || (off % size != 0) || (idx >= MEM_WORDS);
      rd   = 32'h0;
      lat  = 1;
      if (err) return;
      w    = longint'(ref_mem[idx]);
      mask = (64'd1 << (8 * size)) - 1;
      if (!st) begin
         v = (w >> (8 * off)) & mask;
         if ((f3 == 3'd0 || f3 == 3'd1) && v >= (mask + 1) / 2)
            v = v + (64'hFFFF_FFFF - mask);
         rd  = v[31:0];
         lat = 2;
      end else begin
         v = (w & ~(mask << (8 * off))) | ((longint'(wd) & mask) << (8 * off));
         ref_mem[idx] = v[31:0];
         lat = (size == 4) ? 2 : 3;
      end
   endtask

   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int hold);
      logic        e_err;
      logic [31:0] e_rd;
      int          e_lat, cyc, rd0, wd0;
      model(st, f3, a, wd, e_err, e_rd, e_lat);
      rd0 = rd_cnt;
      wd0 = wd_cnt;
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      resp_ready = (hold == 0);
      req_valid  = 1'b1;
      req_store  = st;
      req_fun3   = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      cyc = 1;
      @(negedge clk);
      while (!resp_valid && cyc < 8) begin
         @(negedge clk);
         cyc++;
      end
      check("latency", 32'(cyc), 32'(e_lat));
      check("resp_err", 32'(resp_err), 32'(e_err));
      check("resp_rdata", resp_rdata, e_rd);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         req_store = 1'b0;
         req_fun3  = 3'd2;
         req_addr  = 32'h4;
         @(negedge clk);
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_rdata", resp_rdata, e_rd);
         check("hold_ready", 32'(req_ready), 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      check("resp_drop", 32'(resp_valid), 32'd0);
      check("rd_count", 32'(rd_cnt - rd0), (e_err || (st && f3 == 3'd2)) ? 32'd0 : 32'd1);
      check("wd_count", 32'(wd_cnt - wd0), (!e_err && st) ? 32'd1 : 32'd0);
   endtask

   initial begin
      logic        rnd_st;
      logic [2:0]  rnd_f3;
      logic [31:0] rnd_a;
      int          w0;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_store = 1'b0;
      req_fun3 = 3'd0;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      resp_ready = 1'b1;
      for (int i = 0; i < MEM_WORDS; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[3] = 32'h8899AABB; ref_mem[3] = 32'h8899AABB;
      mem[5] = 32'h11223344; ref_mem[5] = 32'h11223344;
      mem[7] = 32'hCAFEF00D; ref_mem[7] = 32'hCAFEF00D;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("rst_wd_en", 32'(mem_wd_en), 32'd0);
      check("rst_mem_address", mem_address, 32'h0);
      check("mem_fun3", 32'(mem_fun3), 32'd2);
      rst_n = 1'b1;

      do_req(1'b0, 3'b000, 32'h0D, 32'h0, 0);
      do_req(1'b0, 3'b101, 32'h0E, 32'h0, 0);
      do_req(1'b0, 3'b001, 32'h0C, 32'h0, 0);
      do_req(1'b1, 3'b000, 32'h15, 32'hEE, 0);
      check("sb_word", mem[5], 32'h1122EE44);
      do_req(1'b1, 3'b010, 32'h06, 32'h12345678, 0);
      do_req(1'b0, 3'b010, 32'hA0, 32'h0, 0);
      do_req(1'b1, 3'b100, 32'h10, 32'h55, 0);
      do_req(1'b0, 3'b011, 32'h10, 32'h0, 0);
      do_req(1'b0, 3'b010, 32'h0C, 32'h0, 4);
      do_req(1'b1, 3'b010, 32'h9C, 32'hDEADBEEF, 1);
      do_req(1'b1, 3'b001, 32'h12, 32'hABCD9876, 0);

      // Reset while an SH read-modify-write sits in READ: the write must never happen.
      w0 = wd_cnt;
      @(negedge clk);
      req_valid = 1'b1;
      req_store = 1'b1;
      req_fun3  = 3'b001;
      req_addr  = 32'h1E;
      req_wdata = 32'h0000BEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("sh_in_read", 32'(mem_rd_en), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_ready", 32'(req_ready), 32'd1);
      check("abort_wd_en", 32'(mem_wd_en), 32'd0);
      check("abort_rd_en", 32'(mem_rd_en), 32'd0);
      check("abort_valid", 32'(resp_valid), 32'd0);
      check("abort_wdata", mem_wdata, 32'h0);
      check("abort_rdata", resp_rdata, 32'h0);
      repeat (3) @(negedge clk);
      check("abort_no_write", 32'(wd_cnt - w0), 32'd0);
      check("abort_word", mem[7], 32'hCAFEF00D);

      for (int n = 0; n < 150; n++) begin
         rnd_st = 1'($urandom_range(0, 1));
         rnd_f3 = 3'($urandom_range(0, 7));
         rnd_a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * MEM_WORDS + 7));
         do_req(rnd_st, rnd_f3, rnd_a, $urandom, $urandom_range(0, 2));
      end

      for (int i = 0; i < MEM_WORDS; i++)
         check($sformatf("mem_%0d", i), mem[i], ref_mem[i]);
      check("rd_wd_overlap", 32'(both_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
